// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: default widths, ROM contents and the fetch entry type.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;

    // One buffered fetch: the address and the word read from it.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Default ROM image: {a, ~a}. The 32-bit result is zero above 2*addr_w bits,
    // so the caller truncates or zero-extends it to its word width.
    function automatic logic [31:0] rom_word(input logic [31:0] addr,
                                             input int unsigned addr_w = DEF_ADDR_W);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return ((addr & mask) << addr_w) | (~addr & mask);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; accepts a push while full when a pop happens the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when nothing is buffered.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: detects pc changes, reads the ROM into a one-entry stage,
// and buffers {pc, instr} pairs in a FIFO for decode. Counts fetches lost to overflow.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  pc_last;
    logic               first;
    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_pc;
    logic [DATA_W-1:0]  s1_instr;
    logic [DATA_W-1:0]  rom_data;
    logic               fetch_evt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               drop;
    logic [ENTRY_W-1:0] fifo_dout;

    assign rom_data  = DATA_W'(rom_word(32'(pc_in), ADDR_W));
    assign fetch_evt = (pc_in != pc_last) || first;

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_dout[ENTRY_W-1:DATA_W];
    assign out_instr = fifo_dout[DATA_W-1:0];

    // A full FIFO still takes the stage-1 entry when decode frees a slot this cycle.
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = s1_valid && (!fifo_full || fifo_pop);
    assign drop      = s1_valid && fifo_full && !fifo_pop && !flush;

    // Event detect and stage-1 register; flush forces a refetch of whatever pc follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_last  <= '0;
            first    <= 1'b1;
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_instr <= '0;
        end else if (flush) begin
            first    <= 1'b1;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= fetch_evt;
            if (fetch_evt) begin
                s1_pc    <= pc_in;
                s1_instr <= rom_data;
                pc_last  <= pc_in;
                first    <= 1'b0;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .din   ({s1_pc, s1_instr}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumes the 4-bit program count produced by the free-running counter stage, which sits directly upstream.
- On every new count value, reads the instruction ROM, pairs the word with its address, and buffers the pair in a small FIFO.
- Downstream decode pops entries with a valid/ready handshake.
- Absorbs decode stalls. Counts and flags fetches lost to overflow.

Parameters:
- ADDR_W, 4: width of pc_in and out_pc; ROM depth is 2**ADDR_W.
- DATA_W, 8: instruction word width.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- pc_in  in  ADDR_W  current count from the upstream counter.
- flush  in  1  discard buffered and in-flight fetches, then refetch the current pc_in.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  ADDR_W  address of the head entry.
- out_instr  out  DATA_W  instruction word of the head entry.
- level  out  clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky; set on any dropped fetch.
- drop_cnt  out  DROP_W  saturating count of dropped fetches.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. Polarity and synchronicity are fixed.
- Reset values:
  - out_valid=0, out_pc=0, out_instr=0, level=0, overflow=0, drop_cnt=0.
  - Stage-1 valid=0. first flag=1.
- ROM: combinational, indexed by pc_in. Default contents: word[a] = {a, ~a} truncated/extended to DATA_W. For DATA_W=8, a=3 gives 8'h3C.
- Fetch event at edge k: (pc_in != pc_last) OR first flag.
  - Stage-1 register loads {valid=1, pc_in, rom[pc_in]}.
  - pc_last <= pc_in; first flag <= 0.
  - With no event, stage-1 valid <= 0.
- Push at edge k+1: stage-1 entry enters the FIFO if not full, or if full with a pop in the same cycle.
  - out_valid rises after edge k+1, so latency is 2 cycles from the sampled pc change.
- Drop: stage-1 valid with FIFO full and no pop.
  - Entry is discarded. overflow <= 1.
  - drop_cnt increments and saturates at all-ones.
- Pop: occurs when out_valid AND out_ready. Head advances at that edge. out_ready with out_valid=0 has no effect.
- Output stability: the head is stable while out_valid=1 and out_ready=0.
- Duplicate suppression: an unchanged pc (counter held, or counter reset while already 0) generates no fetch.
- Wrap-around:
  - 15->0 is a change and is fetched normally.
  - FIFO pointers wrap modulo DEPTH.
  - level is exact from 0 to DEPTH.
- Upstream reset mid-run (pc jumps to 0): treated as an ordinary change. Already-buffered entries are kept.
- flush (not reset) at edge k:
  - FIFO emptied; stage-1 valid cleared; first flag <= 1.
  - pc_in at edge k+1 is refetched.
  - overflow and drop_cnt are kept.
  - flush overrides push and pop in the same cycle.
- Reset overrides flush and every other input.
- overflow and drop_cnt clear only on reset.

Decomposition:
- Package cpu_pkg:
  - ADDR_W and DATA_W defaults.
  - Instruction ROM default-content function rom_word(addr).
  - Shared fetch-entry struct {pc, instr}.
- Sub-module sync_fifo(WIDTH, DEPTH):
  - Ports: clk, reset, clear, push, din, pop, dout, full, empty, level.
  - Synchronous reset; supports push and pop in the same cycle when full.
- instr_fetch holds only event detect, stage 1, drop logic, and the sync_fifo instance.

Test Plan:
- After reset, pc_in=0 held, out_ready=1 -> exactly one entry out_pc=0, out_instr=8'h0F, out_valid high 2 cycles after reset release; no further entries.
- Counter-style stimulus 0..15..0 with out_ready=1 -> 17 entries in order; the pc=15 entry carries 8'hF0; the wrap entry pc=0 carries 8'h0F; level never exceeds 2.
- out_ready=0, pc stepping 1..6 -> level reaches 4 holding pcs 1-4; pcs 5 and 6 dropped; overflow=1, drop_cnt=2; head stays pc=1/8'h1E until ready.
- FIFO full, with a new pc and out_ready=1 in the same cycle -> no drop; level stays 4; order preserved.
- Entries buffered at pc=9, flush pulsed for one cycle -> level=0 next cycle; one refetch of pc=9 (8'h96) appears 2 cycles after flush; drop_cnt unchanged.
- Reset asserted mid-stream with level=3 and overflow=1 -> all outputs zero on the next edge; the first fetch resumes after release.
